// File: rtl/lfsr_srv_pkg.sv
// Shared types and constants for the LFSR random-number server: FSM state
// encoding and default maximal-length feedback polynomials for narrow LFSRs.
package lfsr_srv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [0:0] POLY_W1 = 1'h1;
    localparam logic [1:0] POLY_W2 = 2'h3;
    localparam logic [2:0] POLY_W3 = 3'h6;
    localparam logic [3:0] POLY_W4 = 4'hC;
    localparam logic [4:0] POLY_W5 = 5'h12;
    localparam logic [5:0] POLY_W6 = 6'h30;

    // Returns the maximal-length polynomial for a given width, zero if none known.
    function automatic logic [7:0] default_poly(input int w);
        case (w)
            1:       return {7'd0, POLY_W1};
            2:       return {6'd0, POLY_W2};
            3:       return {5'd0, POLY_W3};
            4:       return {4'd0, POLY_W4};
            5:       return {3'd0, POLY_W5};
            6:       return {2'd0, POLY_W6};
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lfsr.sv
// Right-shifting Galois LFSR with enable; an all-zero state is reloaded with
// the seed so the generator can never lock up.
module lfsr
    import lfsr_srv_pkg::*;
#(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = W'(default_poly(W)),
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] RELOAD = (SEED == {W{1'b0}}) ? W'(1) : SEED;

    logic [W-1:0] q_r;
    logic [W-1:0] step_s;

    // One Galois step: shift right and fold the polynomial in when a one falls out.
    always_comb begin
        step_s = q_r >> 1;
        if (q_r[0]) begin
            step_s = (q_r >> 1) ^ POLY;
        end else begin
            step_s = q_r >> 1;
        end
    end

    // Generator state register with seed reload on reset or lock-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RELOAD;
        end else if (q_r == {W{1'b0}}) begin
            q_r <= RELOAD;
        end else if (en) begin
            q_r <= step_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/lfsr_rand_server.sv
// Round-robin server sharing one LFSR among N requesters; each draw advances
// the LFSR STEPS times. Optional draw counter enabled by LFSR_SRV_STAT_EN.
module lfsr_rand_server
    import lfsr_srv_pkg::*;
#(
    parameter int           N     = 4,
    parameter int           W     = 5,
    parameter logic [W-1:0] POLY  = W'(default_poly(W)),
    parameter logic [W-1:0] SEED  = W'(1),
    parameter int           STEPS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         rvalid,
    output logic [W-1:0] rdata,
    output logic         busy
`ifdef LFSR_SRV_STAT_EN
    ,
    output logic [15:0]  draws
`endif
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(STEPS + 1);

    state_e         state_r, state_nxt;
    logic [CW-1:0]  cnt_r, cnt_nxt;
    logic [IW-1:0]  idx_r, idx_nxt;
    logic [IW-1:0]  ptr_r, ptr_nxt;
    logic [N-1:0]   gnt_r;
    logic           rvalid_r;
    logic           busy_r;
    logic           lfsr_en_s;

    // First set request bit at or above p, wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] sel;
        logic          found;
        int            j;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(p) + i) % N;
            if (!found && r[j]) begin
                sel   = IW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Next-state logic: arbitrate in IDLE, count LFSR steps in RUN, rotate pointer in DONE.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        idx_nxt   = idx_r;
        ptr_nxt   = ptr_r;
        lfsr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != {N{1'b0}}) begin
                    idx_nxt   = rr_pick(req, ptr_r);
                    cnt_nxt   = CW'(STEPS - 1);
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                lfsr_en_s = 1'b1;
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt_r - CW'(1);
                end
            end
            ST_DONE: begin
                if (idx_r == IW'(N - 1)) begin
                    ptr_nxt = {IW{1'b0}};
                end else begin
                    ptr_nxt = idx_r + IW'(1);
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are precomputed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            idx_r    <= {IW{1'b0}};
            ptr_r    <= {IW{1'b0}};
            gnt_r    <= {N{1'b0}};
            rvalid_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            idx_r    <= idx_nxt;
            ptr_r    <= ptr_nxt;
            rvalid_r <= (state_nxt == ST_DONE);
            busy_r   <= (state_nxt != ST_IDLE);
            if (state_nxt == ST_DONE) begin
                gnt_r <= {{(N-1){1'b0}}, 1'b1} << idx_nxt;
            end else begin
                gnt_r <= {N{1'b0}};
            end
        end
    end

    assign gnt    = gnt_r;
    assign rvalid = rvalid_r;
    assign busy   = busy_r;

    lfsr #(
        .W    (W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en_s),
        .q   (rdata)
    );

`ifdef LFSR_SRV_STAT_EN
    logic [15:0] draws_r;

    // Saturating count of completed draws.
    always_ff @(posedge clk) begin
        if (rst) begin
            draws_r <= 16'h0000;
        end else if ((state_r == ST_DONE) && (draws_r != 16'hFFFF)) begin
            draws_r <= draws_r + 16'h0001;
        end else begin
            draws_r <= draws_r;
        end
    end

    assign draws = draws_r;
`endif

endmodule

// File: doc/lfsr_rand_server.md
# lfsr_rand_server

Shares one `lfsr` pseudo-random generator among N requesters. Each draw advances the generator a fixed number of steps, so consecutive outputs are decorrelated. A round-robin arbiter picks one requester per draw, and the FSM gates the LFSR enable for exactly STEPS cycles. The result is then returned with a one-cycle grant pulse. Sits between the random-number consumers in npc (replacement policy, test stimulus) and the single `lfsr` instance.

## Interface
- `N`, 4: number of requesters, ≥ 2
- `W`, 5: LFSR width, passed to `lfsr`
- `POLY`, 5'h12: feedback polynomial, passed to `lfsr`
- `SEED`, 5'h1: reset seed, passed to `lfsr`
- `STEPS`, 5: LFSR advances per draw, ≥ 1
- `clk` input 1: single clock; everything is posedge
- `rst` input 1: synchronous, active-high reset
- `req` input N: per-requester draw request; level, held until the matching `gnt` bit is seen
- `gnt` output N: one-hot grant, valid only while `rvalid` = 1
- `rvalid` output 1: one-cycle pulse; `rdata` is valid
- `rdata` output W: LFSR value after the draw
- `busy` output 1: high while in RUN or DONE

## Operation
- Reset values: state IDLE, `gnt` = 0, `rvalid` = 0, `busy` = 0, `ptr` = 0, `rdata` = SEED (or 1 if SEED == 0), `draws` = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If `req` != 0, select `idx`: the first set bit found searching upward from `ptr`, modulo N.
  - Latch `idx`, load `cnt` = STEPS-1, go to RUN.
  - If `req` == 0, stay in IDLE.
- RUN:
  - LFSR `en` = 1.
  - If `cnt` == 0, go to DONE; otherwise decrement `cnt`.
  - This gives exactly STEPS LFSR advances.
- DONE:
  - `en` = 0, `rvalid` = 1, `gnt` = one-hot(`idx`), `rdata` = LFSR `q` (held stable).
  - Set `ptr` = (`idx`+1) mod N, go to IDLE.
- LFSR `en` is 0 in IDLE and DONE. `rdata` always equals LFSR `q`.
- Dropped request: if `req[idx]` falls during RUN, the draw still completes and `gnt[idx]` still pulses. A requester that is no longer waiting ignores it.
- New requests arriving during RUN or DONE are not sampled. They wait for the next IDLE.
- LFSR all-zero state is recovered inside `lfsr` (reload to seed). The server needs no special handling.
- `cnt` width is $clog2(STEPS+1). `ptr` and `idx` width is $clog2(N).

## Timing
- `req` is sampled in IDLE at edge k.
- RUN occupies cycles k+1 … k+STEPS.
- DONE (`gnt`/`rvalid`) is at cycle k+STEPS+1.
- Throughput: one draw per STEPS+2 cycles. Back-to-back requests restart from IDLE the cycle after DONE.
- All outputs are registered or decoded from registered state; there is no combinational path from `req` to any output.
- `rst` in RUN or DONE: return to IDLE next edge, no `gnt` issued, LFSR reseeded, `ptr` = 0.

## Configuration
- `LFSR_SRV_STAT_EN` defined:
  - Adds output `draws` [15:0].
  - Increments on every DONE cycle and saturates at 16'hFFFF.
  - Cleared by `rst`.
- Not defined: the `draws` port and counter are absent; all other behaviour is identical.

## Structure
- `lfsr_srv_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the default maximal-length POLY constants for W = 1..6 (1'h1, 2'h3, 3'h6, 4'hC, 5'h12, 6'h30).
- One sub-module: the existing `lfsr`, instantiated as `u_lfsr` with `en` driven by the FSM.
- The round-robin picker is an internal function; it is not a separate module.

## Test plan
- Reset with defaults:
  - Stimulus: `req` = 4'b0001 after reset.
  - Response: `gnt` = 4'b0001 and `rvalid` = 1 exactly 6 cycles after sampling, `rdata` = 5'h17; `busy` high for 6 cycles.
- Second draw, same requester:
  - Stimulus: `req[0]` held.
  - Response: next `gnt` = 4'b0001, `rdata` = 5'h18, starting the cycle after the previous DONE.
- Round-robin order:
  - Stimulus: `req` = 4'b1010 with `ptr` = 0.
  - Response: first grant 4'b0010, then 4'b1000, then 4'b0010; `ptr` wraps 3→0.
- Dropped request:
  - Stimulus: `req[2]` raised then dropped at RUN cycle 2.
  - Response: `gnt` = 4'b0100 still pulses once; no further grant.
- Reset mid-draw:
  - Stimulus: `rst` at RUN cycle 3.
  - Response: no `gnt`, `rdata` = 5'h01, `busy` = 0 next cycle; the next draw returns 5'h17.
- `LFSR_SRV_STAT_EN` defined:
  - Stimulus: 3 completed draws, then `rst`.
  - Response: `draws` = 3 before reset, 0 after.
